pipeline_ctrl: RTL and testbench

//  Sequencer for the 5-stage pipeline latches (FD, DE, EM, MW).

---
 rtl/pipeline_regs_pkg.sv | 15 +
 rtl/pipeline_ctrl_load_use_detect.sv | 15 +
 rtl/pipeline_ctrl.sv | 166 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_regs_pkg.sv
// Shared types for the pipeline latch sequencer (pipeline_ctrl and friends).
package pipeline_regs_pkg;

    // Sequencer operating modes
    typedef enum logic [1:0] {
        RUN,
        LUSTALL,
        DRAIN,
        HALTED
    } pctrl_state_t;

    // Width of the halt-drain countdown
    localparam int PCTRL_DRAIN_W = 2;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// load_use_detect: flags an instruction in FD that reads the destination of a load
// sitting in DE. Register r0 is hardwired to zero and never creates a dependency.
module load_use_detect (
    input  logic       de_memread,
    input  logic [4:0] de_rt,
    input  logic [4:0] fd_rs,
    input  logic [4:0] fd_rt,
    input  logic       fd_uses_rt,
    output logic       hazard
);

    assign hazard = de_memread && (de_rt != 5'd0) &&
                    ((fd_rs == de_rt) || (fd_uses_rt && (fd_rt == de_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: sequencer for the FD/DE/EM/MW pipeline latches. Produces latch
// enables/flushes and the PC enable, handling memory-wait freeze, load-use stalls,
// taken-branch flush and the halt drain.
// Optional feature: define PIPE_PERF_CNT_EN to build the saturating stall/flush
// performance counters; otherwise stall_cnt/flush_cnt are tied to zero.
module pipeline_ctrl
    import pipeline_regs_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             em_dmem_req,
    input  logic             de_memread,
    input  logic [4:0]       de_rt,
    input  logic [4:0]       fd_rs,
    input  logic [4:0]       fd_rt,
    input  logic             fd_uses_rt,
    input  logic             branch_taken,
    input  logic             halt_in,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             em_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             em_flush,
    output logic             mw_flush,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The halt cycle itself is the first advancing cycle of the drain
    localparam logic [PCTRL_DRAIN_W-1:0] DRAIN_INIT = PCTRL_DRAIN_W'(DRAIN_CYCLES - 1);
    localparam pctrl_state_t HALT_ENTRY = (DRAIN_CYCLES <= 1) ? HALTED : DRAIN;

    pctrl_state_t             state;
    pctrl_state_t             next_state;
    logic [PCTRL_DRAIN_W-1:0] drain_cnt;
    logic [PCTRL_DRAIN_W-1:0] next_drain_cnt;
    logic                     memwait;
    logic                     load_use;

    load_use_detect u_load_use_detect (
        .de_memread (de_memread),
        .de_rt      (de_rt),
        .fd_rs      (fd_rs),
        .fd_rt      (fd_rt),
        .fd_uses_rt (fd_uses_rt),
        .hazard     (load_use)
    );

    assign memwait = (em_dmem_req & ~dhit) | ~ihit;

    // Mode and drain countdown registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_drain_cnt;
        end
    end

    // Resolve per-cycle priority: reset, halted, memwait, branch, load-use, drain/halt, advance
    always_comb begin
        pc_en          = 1'b1;
        fd_en          = 1'b1;
        de_en          = 1'b1;
        em_en          = 1'b1;
        mw_en          = 1'b1;
        fd_flush       = 1'b0;
        de_flush       = 1'b0;
        em_flush       = 1'b0;
        mw_flush       = 1'b0;
        halt           = 1'b0;
        next_state     = state;
        next_drain_cnt = drain_cnt;

        if (rst) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
            mw_flush = 1'b1;
        end else if (state == HALTED) begin
            halt  = 1'b1;
            pc_en = 1'b0;
            fd_en = 1'b0;
            de_en = 1'b0;
            em_en = 1'b0;
            mw_en = 1'b0;
        end else if (memwait) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            em_en    = 1'b0;
            mw_flush = 1'b1;
        end else if (branch_taken) begin
            fd_flush       = 1'b1;
            de_flush       = 1'b1;
            em_flush       = 1'b1;
            next_state     = RUN;
            next_drain_cnt = '0;
        end else if ((state == RUN) && load_use) begin
            pc_en      = 1'b0;
            fd_en      = 1'b0;
            de_flush   = 1'b1;
            next_state = LUSTALL;
        end else if (state == DRAIN) begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
            if (drain_cnt <= PCTRL_DRAIN_W'(1)) begin
                next_state     = HALTED;
                next_drain_cnt = '0;
            end else begin
                next_drain_cnt = drain_cnt - PCTRL_DRAIN_W'(1);
            end
        end else if (halt_in) begin
            pc_en          = 1'b0;
            fd_flush       = 1'b1;
            next_state     = HALT_ENTRY;
            next_drain_cnt = DRAIN_INIT;
        end else begin
            next_state = RUN;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic stall_evt;
    logic flush_evt;

    assign stall_evt = (state != HALTED) &
                       (memwait | (~branch_taken & (state == RUN) & load_use));
    assign flush_evt = (state != HALTED) & ~memwait & branch_taken;

    // Saturating performance counters, frozen once halted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_evt && (flush_cnt != {CNT_W{1'b1}})) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: scenario tasks plus a randomized run, checked against a
// behavioural model of the pipeline sequencer kept in this bench.
module tb_pipeline_ctrl;

    localparam int CNT_W        = 32;
    localparam int DRAIN_CYCLES = 3;

    // Output vector order: {pc,fd,de,em,mw en, fd,de,em,mw flush, halt}
    localparam logic [9:0] RESET_CTL  = 10'b00000_1111_0;
    localparam logic [9:0] NORMAL_CTL = 10'b11111_0000_0;
    localparam logic [9:0] HALTED_CTL = 10'b00000_0000_1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             ihit, dhit, em_dmem_req, de_memread, fd_uses_rt, branch_taken, halt_in;
    logic [4:0]       de_rt, fd_rs, fd_rt;
    logic             pc_en, fd_en, de_en, em_en, mw_en;
    logic             fd_flush, de_flush, em_flush, mw_flush, halt;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [9:0]       ctl;

    int total = 0;
    int bad   = 0;

    // Model: stopped / draining with advances left / one bubble already inserted
    bit     m_halted;
    bit     m_draining;
    bit     m_bubble;
    int     m_left;
    longint m_stalls;
    longint m_flushes;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst(rst), .ihit(ihit), .dhit(dhit), .em_dmem_req(em_dmem_req),
        .de_memread(de_memread), .de_rt(de_rt), .fd_rs(fd_rs), .fd_rt(fd_rt),
        .fd_uses_rt(fd_uses_rt), .branch_taken(branch_taken), .halt_in(halt_in),
        .pc_en(pc_en), .fd_en(fd_en), .de_en(de_en), .em_en(em_en), .mw_en(mw_en),
        .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
        .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign ctl = {pc_en, fd_en, de_en, em_en, mw_en, fd_flush, de_flush, em_flush, mw_flush, halt};

    function automatic bit mem_busy();
        return (em_dmem_req && !dhit) || !ihit;
    endfunction

    function automatic bit raw_hazard();
        return de_memread && (de_rt != 5'd0) &&
               ((fd_rs == de_rt) || (fd_uses_rt && (fd_rt == de_rt)));
    endfunction

    function automatic logic [9:0] exp_ctl();
        if (m_halted)                               return HALTED_CTL;
        if (mem_busy())                             return 10'b00001_0001_0;
        if (branch_taken)                           return 10'b11111_1110_0;
        if (!m_draining && !m_bubble && raw_hazard()) return 10'b00111_0100_0;
        if (m_draining || halt_in)                  return 10'b01111_1000_0;
        return NORMAL_CTL;
    endfunction

    function automatic logic [2*CNT_W-1:0] exp_cnts();
`ifdef PIPE_PERF_CNT_EN
        return {CNT_W'(m_stalls), CNT_W'(m_flushes)};
`else
        return '0;
`endif
    endfunction

    task automatic model_reset();
        m_halted   = 0;
        m_draining = 0;
        m_bubble   = 0;
        m_left     = 0;
        m_stalls   = 0;
        m_flushes  = 0;
    endtask

    task automatic model_clock();
        if (m_halted) return;
        if (mem_busy()) begin
            m_stalls++;
            return;
        end
        if (branch_taken) begin
            m_flushes++;
            m_draining = 0;
            m_bubble   = 0;
            return;
        end
        if (!m_draining && !m_bubble && raw_hazard()) begin
            m_stalls++;
            m_bubble = 1;
            return;
        end
        m_bubble = 0;
        if (m_draining) begin
            m_left--;
            if (m_left <= 0) begin
                m_halted   = 1;
                m_draining = 0;
            end
        end else if (halt_in) begin
            m_draining = 1;
            m_left     = DRAIN_CYCLES - 1;
        end
    endtask

    task automatic drive(input bit ih, input bit dh, input bit emreq, input bit dmr,
                         input logic [4:0] drt, input logic [4:0] rs, input logic [4:0] rt,
                         input bit urt, input bit br, input bit hlt);
        ihit = ih; dhit = dh; em_dmem_req = emreq; de_memread = dmr;
        de_rt = drt; fd_rs = rs; fd_rt = rt; fd_uses_rt = urt;
        branch_taken = br; halt_in = hlt;
    endtask

    task automatic rand_drive();
        drive($urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
              $urandom_range(0, 19) == 0);
    endtask

    task automatic test_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        total++;
        if (ctl !== RESET_CTL) begin
            bad++; $display("FAIL reset_hold ctl got=%b want=%b", ctl, RESET_CTL);
        end
        total++;
        if ({stall_cnt, flush_cnt} !== '0) begin
            bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #2;
        total++;
        if (ctl !== NORMAL_CTL) begin
            bad++; $display("FAIL reset_release ctl got=%b want=%b", ctl, NORMAL_CTL);
        end
        model_clock();
        @(negedge clk);
        drive(1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
        #2;
        total++;
        if (ctl !== exp_ctl()) begin
            bad++; $display("FAIL reset_prestall ctl got=%b want=%b", ctl, exp_ctl());
        end
        model_clock();
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        total++;
        if (ctl !== RESET_CTL) begin
            bad++; $display("FAIL reset_async ctl got=%b want=%b", ctl, RESET_CTL);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        total++;
        if (ctl !== 10'b00111_0100_0 || ctl !== exp_ctl()) begin
            bad++; $display("FAIL reset_nostate ctl got=%b want=%b", ctl, exp_ctl());
        end
        model_clock();
        @(negedge clk);
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 8; i++) begin
            case (i)
                1, 2:    drive(1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
                3:       drive(1, 1, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
                4:       drive(1, 1, 0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0);
                5:       drive(1, 1, 0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0);
                default: drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
            endcase
            #2;
            total++;
            if (ctl !== exp_ctl()) begin
                bad++; $display("FAIL load_use[%0d] ctl got=%b want=%b", i, ctl, exp_ctl());
            end
            total++;
            if ({stall_cnt, flush_cnt} !== exp_cnts()) begin
                bad++; $display("FAIL load_use_cnt[%0d] got=%0d/%0d want=%h", i, stall_cnt, flush_cnt, exp_cnts());
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_memwait();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 1, 2, 3: drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
                4:          drive(1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
                default:    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
            endcase
            #2;
            total++;
            if (ctl !== exp_ctl()) begin
                bad++; $display("FAIL memwait[%0d] ctl got=%b want=%b", i, ctl, exp_ctl());
            end
            total++;
            if ({stall_cnt, flush_cnt} !== exp_cnts()) begin
                bad++; $display("FAIL memwait_cnt[%0d] got=%0d/%0d want=%h", i, stall_cnt, flush_cnt, exp_cnts());
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 4:    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
                2, 3:    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
                default: drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
            endcase
            #2;
            total++;
            if (ctl !== exp_ctl()) begin
                bad++; $display("FAIL branch[%0d] ctl got=%b want=%b", i, ctl, exp_ctl());
            end
            total++;
            if ({stall_cnt, flush_cnt} !== exp_cnts()) begin
                bad++; $display("FAIL branch_cnt[%0d] got=%0d/%0d want=%h", i, stall_cnt, flush_cnt, exp_cnts());
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 11; i++) begin
            case (i)
                0:       drive(1, 1, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 1);
                1:       drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
                3, 4:    drive(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
                2, 5:    drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
                default: rand_drive();
            endcase
            #2;
            total++;
            if (ctl !== exp_ctl()) begin
                bad++; $display("FAIL halt[%0d] ctl got=%b want=%b", i, ctl, exp_ctl());
            end
            if (i >= 6) begin
                total++;
                if (ctl !== HALTED_CTL) begin
                    bad++; $display("FAIL halt_stop[%0d] ctl got=%b want=%b", i, ctl, HALTED_CTL);
                end
            end
            total++;
            if ({stall_cnt, flush_cnt} !== exp_cnts()) begin
                bad++; $display("FAIL halt_cnt[%0d] got=%0d/%0d want=%h", i, stall_cnt, flush_cnt, exp_cnts());
            end
            model_clock();
            @(negedge clk);
        end
        #3 rst = 1'b1;
        #1;
        total++;
        if (ctl !== RESET_CTL) begin
            bad++; $display("FAIL halt_reset ctl got=%b want=%b", ctl, RESET_CTL);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_branch_in_drain();
        for (int i = 0; i < 9; i++) begin
            case (i)
                0:       drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
                2:       drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
                default: drive(1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
            endcase
            #2;
            total++;
            if (ctl !== exp_ctl()) begin
                bad++; $display("FAIL drain_branch[%0d] ctl got=%b want=%b", i, ctl, exp_ctl());
            end
            if (i >= 3) begin
                total++;
                if (halt !== 1'b0) begin
                    bad++; $display("FAIL drain_branch_halt[%0d] got=%b want=0", i, halt);
                end
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int halted_for = 0;
        for (int i = 0; i < 2000; i++) begin
            if (m_halted) halted_for++;
            if (halted_for > 3) begin
                halted_for = 0;
                rst = 1'b1;
                #2;
                total++;
                if (ctl !== RESET_CTL) begin
                    bad++; $display("FAIL random_reset[%0d] ctl got=%b want=%b", i, ctl, RESET_CTL);
                end
                model_reset();
                @(negedge clk);
                rst = 1'b0;
            end
            rand_drive();
            #2;
            total++;
            if (ctl !== exp_ctl()) begin
                bad++; $display("FAIL random[%0d] ctl got=%b want=%b", i, ctl, exp_ctl());
            end
            total++;
            if ({stall_cnt, flush_cnt} !== exp_cnts()) begin
                bad++; $display("FAIL random_cnt[%0d] got=%0d/%0d want=%h", i, stall_cnt, flush_cnt, exp_cnts());
            end
            model_clock();
            @(negedge clk);
        end
    endtask

    // Run every scenario in order, then report
    initial begin
        model_reset();
        $display("[TB] pipeline_ctrl bench start");
        test_reset();
        test_load_use();
        test_memwait();
        test_branch();
        test_halt();
        test_branch_in_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
